// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo
// Stereo sample FIFO between an upstream sample-clock domain (synchronous
// strobe) and an HDMI audio packetizer. Show-ahead output, sticky overflow,
// drop-on-full. Build macro AUDIO_BLOCK_START_EN adds an IEC 60958
// block-start flag carried with every entry (192-frame block counter).
module audio_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sampleClkIn,
  input  logic signed [WIDTH-1:0]   datInL,
  input  logic signed [WIDTH-1:0]   datInR,
  input  logic                      sampleReady,
  input  logic                      clrOvf,
  output logic                      sampleValid,
  output logic signed [WIDTH-1:0]   sampleL,
  output logic signed [WIDTH-1:0]   sampleR,
  output logic [$clog2(DEPTH):0]    level,
`ifdef AUDIO_BLOCK_START_EN
  output logic                      blockStart,
`endif
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          clk_prev_q;
  logic          primed_q, primed_d;

  logic signed [WIDTH-1:0] mem_l_q [DEPTH];
  logic signed [WIDTH-1:0] mem_r_q [DEPTH];

  logic capture, pop, full, push, drop;

  // Edge detect on the sample strobe, pop/push qualification.
  always_comb begin
    capture = sampleClkIn & ~clk_prev_q;
    full    = (level_q == FULL_LVL);
    pop     = sampleValid & sampleReady;
    push    = capture & (~full | pop);
    drop    = capture & full & ~pop;
  end

  // Next-state for pointers, level, overflow and the head-read gate.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    primed_d = primed_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      primed_d = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // A drop in the same cycle as a clear leaves the flag set.
    if (drop)        ovf_d = 1'b1;
    else if (clrOvf) ovf_d = 1'b0;
  end

  // Control state; previous strobe resets high so a held-high strobe is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      clk_prev_q <= 1'b1;
      primed_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      clk_prev_q <= sampleClkIn;
      primed_q   <= primed_d;
    end
  end

  // Sample storage; contents are not reset, the read path is gated instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_l_q[wr_ptr_q] <= datInL;
      mem_r_q[wr_ptr_q] <= datInR;
    end
  end

`ifdef AUDIO_BLOCK_START_EN
  logic [7:0]  frame_q, frame_d;
  logic        mem_bs_q [DEPTH];

  // Frame counter advances only on accepted pushes, wrapping 191 -> 0.
  always_comb begin
    frame_d = frame_q;
    if (push) frame_d = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_q <= 8'd0;
    else      frame_q <= frame_d;
  end

  // Block-start flag stored alongside each sample pair.
  always_ff @(posedge clk) begin
    if (push) mem_bs_q[wr_ptr_q] <= (frame_q == 8'd0);
  end

  assign blockStart = primed_q & mem_bs_q[rd_ptr_q];
`endif

  assign sampleValid = (level_q != '0);
  assign level       = level_q;
  assign overflow    = ovf_q;
  assign sampleL     = primed_q ? mem_l_q[rd_ptr_q] : '0;
  assign sampleR     = primed_q ? mem_r_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo (DEPTH=8, WIDTH=16) with a
// queue-based scoreboard. Block-start checks compile in when
// AUDIO_BLOCK_START_EN is defined.
module tb_audio_sample_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic sampleClkIn = 1'b0;
  logic signed [WIDTH-1:0] datInL = '0;
  logic signed [WIDTH-1:0] datInR = '0;
  logic sampleReady = 1'b0;
  logic clrOvf = 1'b0;
  logic sampleValid;
  logic signed [WIDTH-1:0] sampleL;
  logic signed [WIDTH-1:0] sampleR;
  logic [$clog2(DEPTH):0] level;
  logic overflow;
`ifdef AUDIO_BLOCK_START_EN
  logic blockStart;
`endif

  audio_sample_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .sampleClkIn(sampleClkIn),
    .datInL(datInL), .datInR(datInR),
    .sampleReady(sampleReady), .clrOvf(clrOvf),
    .sampleValid(sampleValid), .sampleL(sampleL), .sampleR(sampleR),
    .level(level),
`ifdef AUDIO_BLOCK_START_EN
    .blockStart(blockStart),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        bs;
    logic [15:0] l;
    logic [15:0] r;
  } entry_t;

  entry_t sb[$];
  logic   m_prev;
  logic   m_ovf;
  int     m_cnt;
  int     n_chk = 0;
  int     n_fail = 0;
  int     bs_seen = 0;

  // One clock of the reference model: evaluate pops/pushes from the inputs
  // currently applied, advance the DUT one edge, then check its state.
  task automatic step();
    logic cap, popm, dropm;
    entry_t e;
    cap   = sampleClkIn & ~m_prev;
    popm  = (sb.size() != 0) && sampleReady;
    dropm = 1'b0;
    if (popm) begin
      n_chk++;
      if ({sampleL, sampleR} !== {sb[0].l, sb[0].r}) begin
        n_fail++;
        $display("FAIL pop_data: got %h/%h expected %h/%h", sampleL, sampleR, sb[0].l, sb[0].r);
      end
`ifdef AUDIO_BLOCK_START_EN
      n_chk++;
      if (blockStart !== sb[0].bs) begin
        n_fail++;
        $display("FAIL pop_blockstart: got %b expected %b", blockStart, sb[0].bs);
      end
      if (blockStart === 1'b1) bs_seen++;
`endif
      void'(sb.pop_front());
    end
    if (cap) begin
      if (sb.size() < DEPTH) begin
        e.l  = datInL;
        e.r  = datInR;
        e.bs = (m_cnt == 0);
        m_cnt = (m_cnt == 191) ? 0 : m_cnt + 1;
        sb.push_back(e);
      end else dropm = 1'b1;
    end
    if (dropm) m_ovf = 1'b1;
    else if (clrOvf) m_ovf = 1'b0;
    m_prev = sampleClkIn;
    @(posedge clk);
    #1;
    n_chk++;
    if (level !== 4'(sb.size())) begin
      n_fail++;
      $display("FAIL level: got %0d expected %0d", level, sb.size());
    end
    n_chk++;
    if (sampleValid !== (sb.size() != 0)) begin
      n_fail++;
      $display("FAIL sampleValid: got %b expected %b", sampleValid, sb.size() != 0);
    end
    n_chk++;
    if (overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL overflow: got %b expected %b", overflow, m_ovf);
    end
  endtask

  // One capture: a low cycle, then the rising strobe with the given ready.
  task automatic ev(input logic [15:0] l, input logic [15:0] r, input logic rdy);
    sampleClkIn = 1'b0;
    sampleReady = 1'b0;
    step();
    sampleClkIn = 1'b1;
    datInL      = l;
    datInR      = r;
    sampleReady = rdy;
    step();
    sampleReady = 1'b0;
  endtask

  task automatic drain();
    sampleClkIn = 1'b0;
    sampleReady = 1'b1;
    repeat (DEPTH + 2) step();
    sampleReady = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    sb.delete();
    m_prev = 1'b1;
    m_ovf  = 1'b0;
    m_cnt  = 0;
    n_chk++;
    if ({sampleValid, level, overflow} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got valid=%b level=%0d ovf=%b expected 0/0/0", sampleValid, level, overflow);
    end
    n_chk++;
    if ({sampleL, sampleR} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_head: got %h/%h expected 0000/0000", sampleL, sampleR);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    ev(16'h1234, 16'hEDCC, 1'b0);
    n_chk++;
    if (sampleValid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_latency: got valid=%b expected 1", sampleValid);
    end
    ev(16'h0001, 16'hFFFF, 1'b0);
    ev(16'h8000, 16'h7FFF, 1'b0);
    n_chk++;
    if ({level, sampleL, sampleR} !== {4'd3, 16'h1234, 16'hEDCC}) begin
      n_fail++;
      $display("FAIL basic_head: got level=%0d %h/%h expected 3 1234/edcc", level, sampleL, sampleR);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [31:0] hold;
    do_reset();
    ev(16'hA5A5, 16'h5A5A, 1'b0);
    ev(16'h0F0F, 16'hF0F0, 1'b0);
    hold = {sampleL, sampleR};
    repeat (4) begin
      step();
      n_chk++;
      if ({sampleL, sampleR} !== hold) begin
        n_fail++;
        $display("FAIL stall_stable: got %h expected %h", {sampleL, sampleR}, hold);
      end
    end
    drain();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) ev(16'(16'h100 + i), 16'(16'h200 + i), 1'b0);
    n_chk++;
    if ({level, overflow} !== {4'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_full: got level=%0d ovf=%b expected 8/1", level, overflow);
    end
    clrOvf = 1'b1;
    step();
    clrOvf = 1'b0;
    n_chk++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
    clrOvf = 1'b1;
    ev(16'hDEAD, 16'hBEEF, 1'b0);
    clrOvf = 1'b0;
    n_chk++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got %b expected 1", overflow);
    end
    drain();
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 8; i++) ev(16'(16'h300 + i), 16'(16'h400 + i), 1'b0);
    ev(16'h7777, 16'h8888, 1'b1);
    n_chk++;
    if ({level, overflow} !== {4'd8, 1'b0}) begin
      n_fail++;
      $display("FAIL full_pop: got level=%0d ovf=%b expected 8/0", level, overflow);
    end
    drain();
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    ev(16'h4321, 16'hBCDE, 1'b1);
    n_chk++;
    if ({level, sampleL, sampleR} !== {4'd1, 16'h4321, 16'hBCDE}) begin
      n_fail++;
      $display("FAIL empty_pushpop: got level=%0d %h/%h expected 1 4321/bcde", level, sampleL, sampleR);
    end
    drain();
  endtask

  task automatic test_strobe_high_reset();
    ev(16'h1111, 16'h2222, 1'b0);
    sampleClkIn = 1'b1;
    do_reset();
    repeat (3) step();
    n_chk++;
    if (level !== 4'd0) begin
      n_fail++;
      $display("FAIL held_high: got level=%0d expected 0", level);
    end
    ev(16'h6666, 16'h9999, 1'b0);
    n_chk++;
    if ({level, sampleL} !== {4'd1, 16'h6666}) begin
      n_fail++;
      $display("FAIL after_held: got level=%0d %h expected 1 6666", level, sampleL);
    end
    drain();
  endtask

  task automatic test_midstream_reset();
    for (int i = 0; i < 5; i++) ev(16'(16'h500 + i), 16'(16'h600 + i), 1'b0);
    sampleClkIn = 1'b0;
    do_reset();
    ev(16'h0ABC, 16'h0DEF, 1'b0);
    n_chk++;
    if ({level, sampleL, sampleR} !== {4'd1, 16'h0ABC, 16'h0DEF}) begin
      n_fail++;
      $display("FAIL mid_reset: got level=%0d %h/%h expected 1 0abc/0def", level, sampleL, sampleR);
    end
    drain();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      sampleClkIn = 1'($urandom_range(0, 1));
      sampleReady = ($urandom_range(0, 3) == 0);
      clrOvf      = ($urandom_range(0, 15) == 0);
      datInL      = 16'($urandom);
      datInR      = 16'($urandom);
      step();
    end
    clrOvf = 1'b0;
    drain();
  endtask

`ifdef AUDIO_BLOCK_START_EN
  task automatic test_block_start();
    do_reset();
    bs_seen = 0;
    for (int i = 0; i < 385; i++) ev(16'(i), 16'(~i), 1'b1);
    drain();
    n_chk++;
    if (bs_seen !== 3) begin
      n_fail++;
      $display("FAIL bs_count: got %0d expected 3", bs_seen);
    end
    do_reset();
    for (int i = 0; i < 10; i++) ev(16'(i), 16'(~i), 1'b0);
    for (int i = 10; i < 387; i++) ev(16'(i), 16'(~i), 1'b1);
    drain();
  endtask
`endif

  initial begin
    rst = 1'b1;
    m_prev = 1'b1;
    m_ovf = 1'b0;
    m_cnt = 0;
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_full_pop();
    test_empty_push_pop();
    test_strobe_high_reset();
    test_midstream_reset();
    test_random();
`ifdef AUDIO_BLOCK_START_EN
    test_block_start();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
